snapshot_mem_ext: RTL and testbench
===================================

Name: snapshot_mem_ext

Overview:
- Parametrised successor to the narrow-bus/wide-memory snapshot bridge.
- Bridges a BUS_DATA_WIDTH reg_native_if upstream to a MEM_DATA_WIDTH memory downstream through a PARTITION_CNT-slice snapshot register.
- New over the previous generation:
  - selectable write-trigger slice (first or last), so software can write low-to-high and commit on the final slice;
  - misaligned-address detection;
  - memory-access timeout;
  - an err_vld response qualifier.
- Sits between the register-block decoder and an external memory/RAM wrapper.

Parameters:
- BUS_DATA_WIDTH, 32, upstream data width; power of two, at least 8.
- BUS_ADDR_WIDTH, 64, upstream byte-address width.
- MEM_DATA_WIDTH, 64, memory word width; power-of-two multiple of BUS_DATA_WIDTH; PARTITION_CNT = MEM_DATA_WIDTH/BUS_DATA_WIDTH, 1 or more.
- MEM_ADDR_WIDTH, 32, memory word-address width.
- RST_VALUE, all zeros, snapshot register reset value (MEM_DATA_WIDTH bits).
- WR_TRIGGER_LAST, 0, 0 = write to slice 0 triggers the memory write; 1 = write to slice PARTITION_CNT-1 triggers it.
- TIMEOUT_CYCLES, 256, maximum cycles in ACC_MEM without mem_ack_vld; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- soft_rst  in  1  synchronous soft reset; snapshot contents kept
- req_vld  in  1  upstream request pulse
- ack_vld  out  1  upstream completion, one cycle
- err_vld  out  1  qualifies ack_vld: access failed
- addr  in  BUS_ADDR_WIDTH  byte address
- wr_en  in  1  write request
- rd_en  in  1  read request
- wr_data  in  BUS_DATA_WIDTH  write data
- rd_data  out  BUS_DATA_WIDTH  read data, valid with ack_vld
- mem_req_vld  out  1  memory request, level, held until ack
- mem_ack_vld  in  1  memory completion
- mem_addr  out  MEM_ADDR_WIDTH  memory word address
- mem_wr_en  out  1  memory write
- mem_rd_en  out  1  memory read
- mem_wr_data  out  MEM_DATA_WIDTH  full snapshot word
- mem_rd_data  in  MEM_DATA_WIDTH  memory read word

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. soft_rst is also synchronous.
- Derived constants:
  - BB = log2(BUS_DATA_WIDTH/8).
  - RB = log2(MEM_DATA_WIDTH/8).
  - slice index idx = addr[RB-1:BB] (0 when PARTITION_CNT = 1).
  - misaligned = (BB > 0) and addr[BB-1:0] != 0.
  - WT = 0 if WR_TRIGGER_LAST = 0, else PARTITION_CNT-1.
- Reset (rst or soft_rst):
  - state = IDLE; timeout counter = 0.
  - mem_req_vld, mem_wr_en, mem_rd_en and mem_addr are all 0.
  - ack_vld, err_vld and rd_data are 0.
  - rst loads ss_reg with RST_VALUE; soft_rst leaves ss_reg unchanged.
- States: IDLE, ACC_MEM, READ_SS, ERR (one-hot).
- IDLE, when req_vld=1, decoded in this priority order:
  1. misaligned -> ERR; no ss_reg update.
  2. Write, idx == WT -> ss_reg[idx] <= wr_data; go to ACC_MEM. Next cycle: mem_req_vld=1, mem_wr_en=1, mem_addr = addr[RB+MEM_ADDR_WIDTH-1:RB].
  3. Write, idx != WT -> ss_reg[idx] <= wr_data; ack_vld=1 combinationally in the same cycle; stay in IDLE.
  4. Read, idx == 0 -> ACC_MEM with mem_rd_en=1 and mem_addr as above.
  5. Read, idx != 0 -> READ_SS; one-hot select registered.
- wr_en and rd_en both asserted: treated as misaligned (ERR).
- req_vld outside IDLE: ignored. Upstream allows one outstanding request.
- ACC_MEM:
  - mem_wr_data = ss_reg (this already includes the trigger slice); mem_wr_data = 0 in any other state.
  - Counter increments every cycle spent in ACC_MEM.
  - On mem_ack_vld: ack_vld=1 the same cycle. For a read, rd_data = mem_rd_data[BUS_DATA_WIDTH-1:0] and all of ss_reg <= mem_rd_data. Return to IDLE; mem_* outputs clear on the next edge.
  - On counter == TIMEOUT_CYCLES-1 without ack (TIMEOUT_CYCLES != 0): ack_vld=1, err_vld=1, rd_data=0, ss_reg unchanged, return to IDLE, mem_* outputs clear.
  - mem_ack_vld and timeout in the same cycle: ack wins, no error.
  - A stray mem_ack_vld seen in IDLE is ignored.
- READ_SS: ack_vld=1, rd_data = ss_reg slice selected by the registered one-hot select. Then IDLE.
- ERR: ack_vld=1, err_vld=1, rd_data=0. Then IDLE.
- Latencies:
  - non-trigger write: 0 cycles;
  - snapshot-slice read and error: 1 cycle;
  - memory access: 1 cycle plus memory latency.
- Reset asserted mid-ACC_MEM aborts the access: mem_req_vld drops next cycle and no upstream ack is issued.

Decomposition:
- Shared package snapshot_pkg:
  - state encoding constants (S_IDLE, S_ACC_MEM, S_READ_SS, S_ERR);
  - the BYTE_WIDTH constant;
  - log2 helper.
- Sub-module: reuse the existing one_hot_mux (WIDTH=BUS_DATA_WIDTH, CNT=PARTITION_CNT) for the slice read path.
- Timeout counter and decode stay inline.

Test Plan:
- MEM 64/BUS 32, WR_TRIGGER_LAST=1: write 0x11111111 to addr 0x100, then 0x22222222 to addr 0x104.
  - First write acked in the same cycle, no memory request.
  - Second write: mem_wr_en with mem_addr=0x20 and mem_wr_data=0x2222222211111111; ack on mem_ack_vld.
- WR_TRIGGER_LAST=0, read addr 0x100 with memory returning 0xAAAA5555DEADBEEF after 3 cycles.
  - rd_data=0xDEADBEEF with ack in the mem_ack_vld cycle.
  - A following read of 0x104 returns 0xAAAA5555 one cycle after its request.
- Read addr 0x102 -> ack_vld=1 and err_vld=1 the next cycle; no mem_req_vld; ss_reg unchanged.
- TIMEOUT_CYCLES=8, memory never acks -> ack_vld=1 and err_vld=1 on the 8th ACC_MEM cycle; mem_req_vld low the following cycle; a late mem_ack_vld causes no upstream ack.
- MEM 128/BUS 32: write slices 1..3, then the trigger slice -> mem_wr_data carries all four slices. soft_rst during ACC_MEM -> IDLE with the outputs cleared and ss_reg retained; rst -> ss_reg = RST_VALUE.

Source files
------------

// File: rtl/snapshot_pkg.sv
// Shared definitions for the snapshot memory bridge: state encoding,
// byte width and a constant-foldable log2 helper.
package snapshot_pkg;

   localparam int BYTE_WIDTH = 8;

   typedef enum logic [3:0] {
      S_IDLE    = 4'b0001,
      S_ACC_MEM = 4'b0010,
      S_READ_SS = 4'b0100,
      S_ERR     = 4'b1000
   } state_t;

   // Ceiling log2; log2(1) = 0.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/snapshot_mem_ext_one_hot_mux.sv
// AND-OR multiplexer driven by a one-hot select; an all-zero select yields zero.
module one_hot_mux #(
   parameter int WIDTH = 32,
   parameter int CNT   = 2
) (
   input  logic [CNT-1:0]       sel,
   input  logic [CNT*WIDTH-1:0] data,
   output logic [WIDTH-1:0]     dout
);

   logic [CNT-1:0][WIDTH-1:0] masked;

   generate
      for (genvar gi = 0; gi < CNT; gi++) begin : g_mask
         assign masked[gi] = data[gi*WIDTH +: WIDTH] & {WIDTH{sel[gi]}};
      end
   endgenerate

   always_comb begin
      dout = '0;
      for (int i = 0; i < CNT; i++) dout = dout | masked[i];
   end

endmodule

// File: rtl/snapshot_mem_ext.sv
// Narrow-bus to wide-memory bridge through a sliced snapshot register, with
// selectable write-trigger slice, misalignment detection and access timeout.
module snapshot_mem_ext
   import snapshot_pkg::*;
#(
   parameter int                  BUS_DATA_WIDTH  = 32,
   parameter int                  BUS_ADDR_WIDTH  = 64,
   parameter int                  MEM_DATA_WIDTH  = 64,
   parameter int                  MEM_ADDR_WIDTH  = 32,
   parameter logic [MEM_DATA_WIDTH-1:0] RST_VALUE = '0,
   parameter int                  WR_TRIGGER_LAST = 0,
   parameter int                  TIMEOUT_CYCLES  = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      soft_rst,
   input  logic                      req_vld,
   output logic                      ack_vld,
   output logic                      err_vld,
   input  logic [BUS_ADDR_WIDTH-1:0] addr,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic [BUS_DATA_WIDTH-1:0] wr_data,
   output logic [BUS_DATA_WIDTH-1:0] rd_data,
   output logic                      mem_req_vld,
   input  logic                      mem_ack_vld,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic                      mem_wr_en,
   output logic                      mem_rd_en,
   output logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
   input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data
);

   localparam int PARTITION_CNT = MEM_DATA_WIDTH / BUS_DATA_WIDTH;
   localparam int BB            = log2(BUS_DATA_WIDTH / BYTE_WIDTH);
   localparam int RB            = log2(MEM_DATA_WIDTH / BYTE_WIDTH);
   localparam int IDX_W         = (PARTITION_CNT > 1) ? (RB - BB) : 1;
   localparam int WT            = (WR_TRIGGER_LAST != 0) ? (PARTITION_CNT - 1) : 0;
   localparam int CNT_W         = (TIMEOUT_CYCLES > 1) ? log2(TIMEOUT_CYCLES) : 1;
   localparam bit TO_EN         = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   state_t                      state_reg, state_next;
   logic [MEM_DATA_WIDTH-1:0]   ss_reg, ss_next;
   logic [PARTITION_CNT-1:0]    sel_reg, sel_next;
   logic [CNT_W-1:0]            cnt_reg, cnt_next;
   logic                        mem_req_reg, mem_req_next;
   logic                        mem_wr_reg, mem_wr_next;
   logic                        mem_rd_reg, mem_rd_next;
   logic [MEM_ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;

   logic [IDX_W-1:0]            idx;
   logic                        misaligned;
   logic [MEM_ADDR_WIDTH-1:0]   word_addr;
   logic [BUS_DATA_WIDTH-1:0]   slice_rd;
   logic                        timeout_hit;
   logic                        unused_bits;

   generate
      if (PARTITION_CNT > 1) begin : g_idx
         assign idx = addr[RB-1:BB];
      end else begin : g_idx_one
         assign idx = '0;
      end
      if (BB > 0) begin : g_mis
         assign misaligned = |addr[BB-1:0];
      end else begin : g_mis_none
         assign misaligned = 1'b0;
      end
   endgenerate

   assign word_addr   = addr[RB+MEM_ADDR_WIDTH-1:RB];
   assign timeout_hit = TO_EN && (cnt_reg == TO_LAST);
   assign unused_bits = ^addr;

   one_hot_mux #(
      .WIDTH(BUS_DATA_WIDTH),
      .CNT  (PARTITION_CNT)
   ) u_slice_mux (
      .sel (sel_reg),
      .data(ss_reg),
      .dout(slice_rd)
   );

   always_ff @(posedge clk) begin
      if (rst || soft_rst) begin
         state_reg    <= S_IDLE;
         sel_reg      <= '0;
         cnt_reg      <= '0;
         mem_req_reg  <= 1'b0;
         mem_wr_reg   <= 1'b0;
         mem_rd_reg   <= 1'b0;
         mem_addr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         sel_reg      <= sel_next;
         cnt_reg      <= cnt_next;
         mem_req_reg  <= mem_req_next;
         mem_wr_reg   <= mem_wr_next;
         mem_rd_reg   <= mem_rd_next;
         mem_addr_reg <= mem_addr_next;
      end
   end

   // Soft reset deliberately keeps the snapshot contents.
   always_ff @(posedge clk) begin
      if (rst)            ss_reg <= RST_VALUE;
      else if (!soft_rst) ss_reg <= ss_next;
   end

   always_comb begin
      state_next    = state_reg;
      ss_next       = ss_reg;
      sel_next      = sel_reg;
      cnt_next      = '0;
      mem_req_next  = 1'b0;
      mem_wr_next   = 1'b0;
      mem_rd_next   = 1'b0;
      mem_addr_next = '0;
      ack_vld       = 1'b0;
      err_vld       = 1'b0;
      rd_data       = '0;
      case (state_reg)
         S_IDLE: begin
            if (req_vld) begin
               // Requests naming both or neither direction are rejected like misalignment.
               if (misaligned || (wr_en == rd_en)) begin
                  state_next = S_ERR;
               end else if (wr_en) begin
                  ss_next[int'(idx)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = wr_data;
                  if (idx == IDX_W'(WT)) begin
                     state_next    = S_ACC_MEM;
                     mem_req_next  = 1'b1;
                     mem_wr_next   = 1'b1;
                     mem_addr_next = word_addr;
                  end else begin
                     ack_vld = 1'b1;
                  end
               end else if (idx == '0) begin
                  state_next    = S_ACC_MEM;
                  mem_req_next  = 1'b1;
                  mem_rd_next   = 1'b1;
                  mem_addr_next = word_addr;
               end else begin
                  state_next    = S_READ_SS;
                  sel_next      = '0;
                  sel_next[idx] = 1'b1;
               end
            end
         end
         S_ACC_MEM: begin
            mem_req_next  = mem_req_reg;
            mem_wr_next   = mem_wr_reg;
            mem_rd_next   = mem_rd_reg;
            mem_addr_next = mem_addr_reg;
            cnt_next      = cnt_reg + 1'b1;
            if (mem_ack_vld || timeout_hit) begin
               ack_vld       = 1'b1;
               state_next    = S_IDLE;
               cnt_next      = '0;
               mem_req_next  = 1'b0;
               mem_wr_next   = 1'b0;
               mem_rd_next   = 1'b0;
               mem_addr_next = '0;
               if (!mem_ack_vld) begin
                  err_vld = 1'b1;
               end else if (mem_rd_reg) begin
                  rd_data = mem_rd_data[BUS_DATA_WIDTH-1:0];
                  ss_next = mem_rd_data;
               end
            end
         end
         S_READ_SS: begin
            ack_vld    = 1'b1;
            rd_data    = slice_rd;
            state_next = S_IDLE;
         end
         S_ERR: begin
            ack_vld    = 1'b1;
            err_vld    = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      // An access interrupted by reset must never be reported upstream.
      if (rst || soft_rst) begin
         ack_vld = 1'b0;
         err_vld = 1'b0;
         rd_data = '0;
      end
   end

   assign mem_req_vld = mem_req_reg;
   assign mem_wr_en   = mem_wr_reg;
   assign mem_rd_en   = mem_rd_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_wr_data = (state_reg == S_ACC_MEM) ? ss_reg : '0;

endmodule

// File: tb/tb_snapshot_mem_ext.sv
// Directed bench: three bridge instances (64-bit trigger-last, 64-bit trigger-first
// with timeout, 128-bit with non-zero reset value) share all inputs except req_vld.
module tb_snapshot_mem_ext;

   logic         clk = 1'b0;
   logic         rst, soft_rst;
   logic         req_a, req_b, req_c;
   logic [63:0]  addr;
   logic         wr_en, rd_en;
   logic [31:0]  wr_data;
   logic         mem_ack_vld;
   logic [127:0] mem_rd_data;

   logic ack_a, err_a, mreq_a, mwr_a, mrd_a;
   logic ack_b, err_b, mreq_b, mwr_b, mrd_b;
   logic ack_c, err_c, mreq_c, mwr_c, mrd_c;
   logic [31:0]  rd_a, rd_b, rd_c, maddr_a, maddr_b, maddr_c;
   logic [63:0]  mwd_a, mwd_b;
   logic [127:0] mwd_c;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   snapshot_mem_ext #(.MEM_DATA_WIDTH(64), .WR_TRIGGER_LAST(1), .TIMEOUT_CYCLES(16)) u_a (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .req_vld(req_a), .ack_vld(ack_a),
      .err_vld(err_a), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
      .rd_data(rd_a), .mem_req_vld(mreq_a), .mem_ack_vld(mem_ack_vld), .mem_addr(maddr_a),
      .mem_wr_en(mwr_a), .mem_rd_en(mrd_a), .mem_wr_data(mwd_a), .mem_rd_data(mem_rd_data[63:0]));

   snapshot_mem_ext #(.MEM_DATA_WIDTH(64), .WR_TRIGGER_LAST(0), .TIMEOUT_CYCLES(8)) u_b (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .req_vld(req_b), .ack_vld(ack_b),
      .err_vld(err_b), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
      .rd_data(rd_b), .mem_req_vld(mreq_b), .mem_ack_vld(mem_ack_vld), .mem_addr(maddr_b),
      .mem_wr_en(mwr_b), .mem_rd_en(mrd_b), .mem_wr_data(mwd_b), .mem_rd_data(mem_rd_data[63:0]));

   snapshot_mem_ext #(.MEM_DATA_WIDTH(128), .WR_TRIGGER_LAST(0), .TIMEOUT_CYCLES(0),
      .RST_VALUE(128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000)) u_c (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .req_vld(req_c), .ack_vld(ack_c),
      .err_vld(err_c), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
      .rd_data(rd_c), .mem_req_vld(mreq_c), .mem_ack_vld(mem_ack_vld), .mem_addr(maddr_c),
      .mem_wr_en(mwr_c), .mem_rd_en(mrd_c), .mem_wr_data(mwd_c), .mem_rd_data(mem_rd_data));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_in();
      req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   // which: 0 = u_a, 1 = u_b, 2 = u_c
   task automatic issue(input int which, input logic w, input logic r,
                        input logic [63:0] a, input logic [31:0] d);
      idle_in();
      addr = a; wr_en = w; rd_en = r; wr_data = d;
      case (which)
         0:       req_a = 1'b1;
         1:       req_b = 1'b1;
         default: req_c = 1'b1;
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; soft_rst = 1'b0; idle_in();
      addr = '0; wr_data = '0; mem_ack_vld = 1'b0; mem_rd_data = '0;
      tick(); tick();
      sample();
      check("rst_ack_a", ack_a, 0);
      check("rst_mreq_a", mreq_a, 0);
      check("rst_maddr_b", maddr_b, 0);
      check("rst_rd_c", rd_c, 0);

      // u_a: trigger on last slice
      tick(); rst = 1'b0; issue(0, 1, 0, 64'h100, 32'h11111111);
      sample(); check("a_wr0_ack", ack_a, 1); check("a_wr0_nomem", mreq_a, 0);
      tick(); issue(0, 1, 0, 64'h104, 32'h22222222);
      sample(); check("a_wr1_noack", ack_a, 0);
      tick(); idle_in();
      sample();
      check("a_mreq", mreq_a, 1); check("a_mwr", mwr_a, 1); check("a_mrd", mrd_a, 0);
      check("a_maddr", maddr_a, 32'h20); check("a_mwd", mwd_a, 64'h2222222211111111);
      check("a_noack_wait", ack_a, 0);
      tick(); mem_ack_vld = 1'b1;
      sample(); check("a_ack", ack_a, 1); check("a_err", err_a, 0);
      tick(); mem_ack_vld = 1'b0;
      sample(); check("a_mreq_clr", mreq_a, 0); check("a_mwd_clr", mwd_a, 0);

      // u_b: memory read, then snapshot read
      tick(); issue(1, 0, 1, 64'h100, 0);
      sample(); check("b_rd_noack0", ack_b, 0);
      tick(); idle_in();
      sample(); check("b_mreq", mreq_b, 1); check("b_mrd", mrd_b, 1); check("b_maddr", maddr_b, 32'h20);
      tick();
      sample(); check("b_noack_wait", ack_b, 0);
      tick(); mem_ack_vld = 1'b1; mem_rd_data = 128'hAAAA5555DEADBEEF;
      sample(); check("b_ack", ack_b, 1); check("b_rd_lo", rd_b, 32'hDEADBEEF); check("b_err0", err_b, 0);
      tick(); mem_ack_vld = 1'b0; issue(1, 0, 1, 64'h104, 0);
      sample(); check("b_ss_noack0", ack_b, 0); check("b_mreq_clr", mreq_b, 0);
      tick(); idle_in();
      sample(); check("b_ss_ack", ack_b, 1); check("b_ss_rd", rd_b, 32'hAAAA5555);

      // u_b: error paths
      tick(); issue(1, 0, 1, 64'h102, 0);
      sample(); check("b_mis_noack0", ack_b, 0);
      tick(); idle_in();
      sample(); check("b_mis_ack", ack_b, 1); check("b_mis_err", err_b, 1);
      check("b_mis_rd", rd_b, 0); check("b_mis_nomem", mreq_b, 0);
      tick(); issue(1, 1, 0, 64'h106, 32'h99999999);
      sample(); check("b_miswr_noack0", ack_b, 0);
      tick(); idle_in();
      sample(); check("b_miswr_err", err_b, 1);
      tick(); issue(1, 1, 1, 64'h104, 32'h99999999);
      tick(); idle_in();
      sample(); check("b_both_ack", ack_b, 1); check("b_both_err", err_b, 1);
      tick(); issue(1, 0, 1, 64'h104, 0);
      tick(); idle_in();
      sample(); check("b_ss_kept", rd_b, 32'hAAAA5555); check("b_ss_kept_err", err_b, 0);

      // u_b: timeout after 8 ACC_MEM cycles
      mem_rd_data = '0;
      tick(); issue(1, 0, 1, 64'h108, 0);
      tick(); idle_in();
      for (int k = 2; k <= 7; k++) tick();
      sample(); check("b_to_wait_ack", ack_b, 0); check("b_to_wait_mreq", mreq_b, 1);
      check("b_to_maddr", maddr_b, 32'h21);
      tick();
      sample(); check("b_to_ack", ack_b, 1); check("b_to_err", err_b, 1); check("b_to_rd", rd_b, 0);
      tick(); mem_ack_vld = 1'b1;
      sample(); check("b_to_mreq_clr", mreq_b, 0); check("b_late_ack", ack_b, 0);
      tick(); mem_ack_vld = 1'b0; issue(1, 0, 1, 64'h10C, 0);
      tick(); idle_in();
      sample(); check("b_to_ss_kept", rd_b, 32'hAAAA5555);

      // u_c: 128-bit, reset value, multi-slice write, soft reset, hard reset
      tick(); issue(2, 0, 1, 64'h208, 0);
      tick(); idle_in();
      sample(); check("c_rstval_ack", ack_c, 1); check("c_rstval_rd", rd_c, 32'hCAFE0002);
      for (int i = 1; i <= 3; i++) begin
         tick(); issue(2, 1, 0, 64'h200 + 64'(4 * i), 32'hB0000000 | 32'(i));
         sample(); check("c_slice_ack", ack_c, 1);
      end
      tick(); issue(2, 1, 0, 64'h200, 32'hB0000000);
      sample(); check("c_trig_noack", ack_c, 0);
      tick(); idle_in();
      sample(); check("c_mreq", mreq_c, 1); check("c_mwr", mwr_c, 1); check("c_maddr", maddr_c, 32'h20);
      check("c_mwd", mwd_c, 128'hB0000003_B0000002_B0000001_B0000000);
      for (int k = 0; k < 20; k++) tick();
      sample(); check("c_no_timeout", ack_c, 0); check("c_still_req", mreq_c, 1);
      tick(); soft_rst = 1'b1; mem_ack_vld = 1'b1;
      sample(); check("c_srst_noack", ack_c, 0);
      tick(); soft_rst = 1'b0; mem_ack_vld = 1'b0;
      sample(); check("c_srst_mreq", mreq_c, 0); check("c_srst_mwd", mwd_c, 0); check("c_srst_ack", ack_c, 0);
      tick(); issue(2, 0, 1, 64'h20C, 0);
      tick(); idle_in();
      sample(); check("c_srst_kept", rd_c, 32'hB0000003);
      tick(); rst = 1'b1;
      tick(); rst = 1'b0; issue(2, 0, 1, 64'h20C, 0);
      tick(); idle_in();
      sample(); check("c_rst_val", rd_c, 32'hCAFE0003);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
